// File: rtl/branch_predict_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl_if
// Bundles the pipeline-facing signals of the branch predictor / flush
// controller.
//
// Modports:
//   master : pipeline side. Drives the fetch PC, the EX-stage branch
//            resolution and the stall. Receives the prediction, the flush
//            and the statistics.
//   slave  : predictor side (branch_predict_ctrl).
//
// Signals:
//   stall            pipeline stall; 1 = EX frozen this cycle
//   if_pc            PC being fetched
//   pred_taken       prediction for if_pc (combinational)
//   pred_target      predicted target, 0 when pred_taken = 0
//   ex_valid         EX holds a conditional branch
//   ex_pc            PC of the EX branch
//   ex_pred_taken    prediction carried down with the EX branch
//   ex_pred_target   predicted target carried down with the EX branch
//   ex_taken         resolved outcome
//   ex_target        resolved taken target
//   flush            1-cycle pulse: kill IF/ID, ID/EX and load redirect_pc
//   redirect_pc      correct next PC, valid while flush = 1
//   branch_count     resolved branches (wraps)
//   mispredict_count mispredicted branches (wraps)
// ---------------------------------------------------------------------------
interface branch_predict_ctrl_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output stall, if_pc, ex_valid, ex_pc, ex_pred_taken, ex_pred_target,
           ex_taken, ex_target,
    input  pred_taken, pred_target, flush, redirect_pc, branch_count,
           mispredict_count
  );

  modport slave (
    input  stall, if_pc, ex_valid, ex_pc, ex_pred_taken, ex_pred_target,
           ex_taken, ex_target,
    output pred_taken, pred_target, flush, redirect_pc, branch_count,
           mispredict_count
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
// Fetch-side branch predictor and mispredict/flush controller.
//  - Direct-mapped table of {valid, tag, target, 2-bit counter}, looked up
//    combinationally with the fetch PC.
//  - Branches resolved in EX update the table and the statistics counters.
//  - A mispredict raises a registered one-cycle flush with the redirect PC.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bp       branch_predict_ctrl_if.slave (see interface header)
//
// Parameters:
//   XLEN     address width
//   ENTRIES  table entries, power of two, >= 4
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  branch_predict_ctrl_if.slave  bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Storage
  // valid/counter bits need a reset value, so they live in per-entry flops.
  // Tag and target are only meaningful once valid is set, so they are kept
  // in plain arrays without reset.
  // -------------------------------------------------------------------------
  logic [TAG_W-1:0]           r_tag    [ENTRIES];
  logic [XLEN-1:0]            r_target [ENTRIES];
  logic [ENTRIES-1:0]         w_valid_all;
  logic [ENTRIES-1:0][1:0]    w_ctr_all;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [XLEN-1:0]            r_redirect_pc;
  logic [31:0]                r_branch_count;
  logic [31:0]                r_mispredict_count;

  // -------------------------------------------------------------------------
  // Fetch-side lookup (zero latency, sees pre-update table state)
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic             w_pred_taken;

  assign w_if_idx     = bp.if_pc[IDX_W+1:2];
  assign w_if_tag     = bp.if_pc[XLEN-1:IDX_W+2];
  assign w_if_hit     = w_valid_all[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_pred_taken = w_if_hit && w_ctr_all[w_if_idx][1];

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ? r_target[w_if_idx] : '0;

  // -------------------------------------------------------------------------
  // EX-side resolve
  // The branch sitting in EX during the flush cycle is wrong-path, so it is
  // excluded from resolution entirely.
  // -------------------------------------------------------------------------
  logic             w_flush;
  logic             w_res;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic [1:0]       w_ex_ctr;
  logic [1:0]       w_ctr_next;
  logic [XLEN-1:0]  w_redirect_calc;

  assign w_res        = bp.ex_valid && !bp.stall && !w_flush;
  assign w_mispredict = w_res &&
                        ((bp.ex_taken != bp.ex_pred_taken) ||
                         (bp.ex_taken && (bp.ex_pred_target != bp.ex_target)));

  assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
  assign w_ex_tag = bp.ex_pc[XLEN-1:IDX_W+2];
  assign w_ex_hit = w_valid_all[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_ctr = w_ctr_all[w_ex_idx];

  // Saturating 2-bit counter step
  always_comb begin
    w_ctr_next = w_ex_ctr;
    if (bp.ex_taken) begin
      if (w_ex_ctr != 2'b11) w_ctr_next = w_ex_ctr + 2'b01;
    end else begin
      if (w_ex_ctr != 2'b00) w_ctr_next = w_ex_ctr - 2'b01;
    end
  end

  // Fall-through target wraps at XLEN like the core's PC adder
  assign w_redirect_calc = bp.ex_taken ? bp.ex_target : (bp.ex_pc + XLEN'(4));

  // -------------------------------------------------------------------------
  // Per-entry valid / counter flops
  // A hit updates the counter; a taken miss (re)allocates the entry with a
  // weakly-taken counter, overwriting whatever aliased there before.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic       r_valid;
      logic [1:0] r_ctr;
      logic       w_sel;

      assign w_sel = w_res && (w_ex_idx == IDX_W'(gi));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid <= 1'b0;
          r_ctr   <= 2'b01;
        end else if (w_sel) begin
          if (w_ex_hit) begin
            r_ctr <= w_ctr_next;
          end else if (bp.ex_taken) begin
            r_valid <= 1'b1;
            r_ctr   <= 2'b10;
          end
        end
      end

      assign w_valid_all[gi] = r_valid;
      assign w_ctr_all[gi]   = r_ctr;
    end
  endgenerate

  // Tag/target write: both a taken hit and a taken miss write the same
  // fields (the tag is unchanged on a hit).
  always_ff @(posedge i_clk) begin
    if (w_res && bp.ex_taken) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= bp.ex_target;
    end
  end

  // -------------------------------------------------------------------------
  // Flush FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FLUSH always returns to IDLE; a mispredict cannot occur in FLUSH since
  // resolution is masked there, so back-to-back flushes never arise.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_mispredict) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_flush = 1'b0;
    case (r_state)
      ST_FLUSH: w_flush = 1'b1;
      default:  w_flush = 1'b0;
    endcase
  end

  // Redirect PC captured on the resolving edge so it is stable for the
  // whole flush cycle even though EX has moved on.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_redirect_pc <= '0;
    end else if (w_mispredict) begin
      r_redirect_pc <= w_redirect_calc;
    end
  end

  assign bp.flush       = w_flush;
  assign bp.redirect_pc = r_redirect_pc;

  // -------------------------------------------------------------------------
  // Statistics counters (wrap modulo 2^32)
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_res)        r_branch_count     <= r_branch_count + 32'd1;
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;

endmodule
